boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Sequences the 256-byte synchronous bootstrap ROM after reset.
- Copies LEN bytes from ROM offset 0 into main RAM at DEST_BASE.
- Holds the 6502 halted until the copy completes, then releases it.
- Sits between the ROM, the RAM write port (via the bus mux) and the CPU halt input; a start pulse re-runs the copy, e.g. for a debug-triggered soft boot.

Parameters:
- DEST_BASE, 16'hFF00, RAM byte address receiving ROM byte 0.
- LEN, 256, number of bytes copied; legal range 1..256.
- AUTO_START, 1, 1 = copy begins straight out of reset; 0 = wait in IDLE for start.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to (re)run the copy; honoured only in IDLE or DONE
- rom_addr  out  8  ROM read address; ROM returns data one clk later
- rom_data  in  8  ROM registered read data
- ram_addr  out  16  RAM write address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  write request; held until ram_ack
- ram_ack  in  1  RAM accepted the write this cycle (wait states allowed)
- cpu_halt  out  1  1 = CPU held; equals !done
- busy  out  1  copy in progress
- done  out  1  copy complete
- checksum  out  8  mod-256 sum of all bytes written in the current run

Behaviour:
- Reset (async, rst_n=0):
  - idx=0, checksum=0, wbuf=0.
  - ram_we=0, done=0, cpu_halt=1.
  - state = ADDR if AUTO_START else IDLE; busy=1 in ADDR, 0 in IDLE.
- Reset asserted mid-copy aborts immediately. Bytes already written stay in RAM; the copy restarts from idx 0 after release.
- rom_addr = idx[7:0] in every state.
- States:
  - IDLE: busy=0, done=0, cpu_halt=1. start -> ADDR with idx=0 and checksum=0.
  - ADDR: one cycle; the ROM samples rom_addr on this cycle's closing edge. -> DATA.
  - DATA: rom_data is now valid; capture wbuf<=rom_data. -> WRITE.
  - WRITE: ram_we=1, ram_addr=(DEST_BASE+idx) mod 2^16, ram_wdata=wbuf.
    - ram_ack=0: stay in WRITE; all outputs held stable.
    - ram_ack=1: checksum<=checksum+wbuf (mod 256). If idx==LEN-1 -> DONE, else idx<=idx+1 -> ADDR.
  - DONE: done=1, busy=0, cpu_halt=0, ram_we=0; checksum held. start -> ADDR with idx=0, checksum=0, done=0.
- ram_we is 0 outside WRITE. ram_addr and ram_wdata are don't-care when ram_we=0 but must not glitch while in WRITE.
- Throughput: 3 cycles per byte with zero wait states, plus N cycles per byte for N wait states.
- Latency with ram_ack tied to 1:
  - done rises on the 3*LEN-th rising edge after ADDR is entered.
  - First ram_we is in the third cycle.
- start is ignored in ADDR, DATA and WRITE. start in the same cycle as the final ram_ack is ignored; the block still enters DONE.
- idx is 9 bits internally so LEN=256 terminates correctly. The ROM address uses idx[7:0].
- DEST_BASE+idx wraps modulo 2^16, e.g. FFFF+1 -> 0000.

Decomposition:
- Shared include boot_defs.vh holds:
  - state encodings (IDLE, ADDR, DATA, WRITE, DONE; 3-bit);
  - default DEST_BASE, LEN and AUTO_START;
  - ROM_DEPTH=256.
- No sub-module. The block is a single FSM plus idx counter, wbuf and checksum accumulator, instantiated next to the ROM in the top level.

Test Plan:
1. ROM preloaded with byte i = i ^ 8'h5A, ram_ack tied 1, AUTO_START=1; release rst_n -> 256 writes to FF00..FFFF with correct data; done rises exactly 768 edges later; cpu_halt falls with it; checksum matches model.
2. ram_ack random, 0-3 wait states per write -> ram_we, ram_addr and ram_wdata stable while un-acked; same RAM image and checksum as scenario 1; no duplicate or skipped addresses.
3. DEST_BASE=16'hFFF0, LEN=32 -> writes to FFF0..FFFF then 0000..000F in order; done after 96 cycles.
4. LEN=1 -> exactly one write of ROM[0] to DEST_BASE; done after 3 cycles; checksum = ROM[0].
5. rst_n pulsed low during byte 100's WRITE -> ram_we drops asynchronously; cpu_halt=1; copy restarts at idx 0 after release and completes normally.
6. AUTO_START=0 -> block stays in IDLE with cpu_halt=1 until start. start pulses during copy -> ignored. start in DONE -> done drops next cycle, full recopy, checksum recomputed from 0.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// boot_loader_pkg
// Shared definitions for the bootstrap copy engine:
//   - state_e       : FSM state encoding (3-bit)
//   - DEF_*         : default destination base, copy length and auto-start
//   - ROM_DEPTH     : depth of the bootstrap ROM in bytes
//   - dest_addr()   : RAM destination address for a given copy index
// -----------------------------------------------------------------------------
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [15:0] DEF_DEST_BASE  = 16'hFF00;
  localparam int          DEF_LEN        = 256;
  localparam bit          DEF_AUTO_START = 1'b1;
  localparam int          ROM_DEPTH      = 256;

  // Destination address wraps modulo 2^16 (e.g. FFFF + 1 -> 0000).
  function automatic logic [15:0] dest_addr(input logic [15:0] base,
                                            input logic [8:0]  idx);
    return base + {7'd0, idx};
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// -----------------------------------------------------------------------------
// boot_loader_if
// Groups the ROM read port and the RAM write port used by the copy engine.
//   rom_addr  : ROM read address (ROM answers one clk later)
//   rom_data  : ROM registered read data
//   ram_addr  : RAM write address
//   ram_wdata : RAM write data
//   ram_we    : write request, held until ram_ack
//   ram_ack   : RAM accepted the write this cycle
// master = the boot loader, slave = ROM / RAM side.
// -----------------------------------------------------------------------------
interface boot_loader_if;
  import boot_loader_pkg::*;

  logic [$clog2(ROM_DEPTH)-1:0] rom_addr;
  logic [7:0]                   rom_data;
  logic [15:0]                  ram_addr;
  logic [7:0]                   ram_wdata;
  logic                         ram_we;
  logic                         ram_ack;

  modport master (
    output rom_addr,
    input  rom_data,
    output ram_addr,
    output ram_wdata,
    output ram_we,
    input  ram_ack
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  ram_addr,
    input  ram_wdata,
    input  ram_we,
    output ram_ack
  );

endinterface

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
// Copies LEN bytes of the bootstrap ROM (offset 0) into RAM at DEST_BASE and
// keeps the CPU halted until the copy is complete. A start pulse in IDLE or
// DONE (re)runs the copy.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle (re)run request, honoured in IDLE / DONE only
//   bus        : ROM read + RAM write port (boot_loader_if.master)
//   cpu_halt   : 1 while the CPU must stay halted (= !done)
//   busy       : copy in progress
//   done       : copy complete
//   checksum   : mod-256 sum of all bytes written in the current run
// -----------------------------------------------------------------------------
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [15:0] DEST_BASE  = DEF_DEST_BASE,
  parameter int          LEN        = DEF_LEN,        // 1..256
  parameter bit          AUTO_START = DEF_AUTO_START
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  boot_loader_if.master        bus,
  output logic                 cpu_halt,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           checksum
);

  localparam state_e     RESET_STATE = AUTO_START ? ST_ADDR : ST_IDLE;
  // 9-bit index so that LEN=256 reaches its last index (255) without aliasing.
  localparam logic [8:0] LAST_IDX    = 9'(LEN - 1);

  state_e      state_q,    state_d;
  logic [8:0]  idx_q,      idx_d;
  logic [7:0]  wbuf_q,     wbuf_d;
  logic [7:0]  csum_q,     csum_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic        ram_we_q,   ram_we_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wbuf_d     = wbuf_q;
    csum_d     = csum_q;
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADDR;
          idx_d   = '0;
          csum_d  = '0;
          busy_d  = 1'b1;
        end
      end

      // rom_addr (= idx) is sampled by the ROM on the closing edge of ADDR.
      ST_ADDR: state_d = ST_DATA;

      // ROM data is valid now. The write address is registered here as well
      // so ram_addr/ram_wdata/ram_we all come from flops during WRITE and
      // cannot glitch while the RAM inserts wait states.
      ST_DATA: begin
        wbuf_d     = bus.rom_data;
        ram_addr_d = dest_addr(DEST_BASE, idx_q);
        ram_we_d   = 1'b1;
        state_d    = ST_WRITE;
      end

      ST_WRITE: begin
        if (bus.ram_ack) begin
          csum_d = csum_q + wbuf_q;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = ST_ADDR;
          end
        end else begin
          ram_we_d = 1'b1;
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d = ST_ADDR;
          idx_d   = '0;
          csum_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end

      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      idx_q      <= '0;
      wbuf_q     <= '0;
      csum_q     <= '0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      busy_q     <= AUTO_START;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wbuf_q     <= wbuf_d;
      csum_q     <= csum_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rom_addr  = idx_q[7:0];
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = wbuf_q;
  assign bus.ram_we    = ram_we_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cpu_halt      = ~done_q;
  assign checksum      = csum_q;

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
// Four boot_loader instances with different parameters share one clock; only
// the selected instance is out of reset and acknowledged at any time.
// A scoreboard queue holds the expected (address, data) writes for a run and
// the monitor pops/compares on each acknowledged write.
// -----------------------------------------------------------------------------
module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam int          N_INST          = 4;
  localparam logic [15:0] P_BASE [N_INST] = '{16'hFF00, 16'hFFF0, 16'hFF00, 16'h1000};
  localparam int          P_LEN  [N_INST] = '{256, 32, 1, 16};
  localparam bit          P_AUTO [N_INST] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [N_INST];
  logic        start     [N_INST];
  logic        mon_we    [N_INST];
  logic [15:0] mon_addr  [N_INST];
  logic [7:0]  mon_wdata [N_INST];
  logic        mon_halt  [N_INST];
  logic        mon_busy  [N_INST];
  logic        mon_done  [N_INST];
  logic [7:0]  mon_csum  [N_INST];

  int   sel      = 0;
  bit   ack_mode = 1'b0;   // 0: ack on first WRITE cycle, 1: 0..3 wait states
  logic ack_r    = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] exp_q [$];

  function automatic logic [7:0] rom_byte(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < N_INST; gi++) begin : g_dut
    boot_loader_if u_if ();
    logic [7:0] rom_q;

    always @(posedge clk) rom_q <= rom_byte(u_if.rom_addr);
    assign u_if.rom_data = rom_q;
    assign u_if.ram_ack  = (sel == gi) ? ack_r : 1'b0;

    boot_loader #(
      .DEST_BASE (P_BASE[gi]),
      .LEN       (P_LEN[gi]),
      .AUTO_START(P_AUTO[gi])
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n[gi]),
      .start   (start[gi]),
      .bus     (u_if),
      .cpu_halt(mon_halt[gi]),
      .busy    (mon_busy[gi]),
      .done    (mon_done[gi]),
      .checksum(mon_csum[gi])
    );

    assign mon_we[gi]    = u_if.ram_we;
    assign mon_addr[gi]  = u_if.ram_addr;
    assign mon_wdata[gi] = u_if.ram_wdata;
  end

  // RAM-side model and scoreboard checker for the selected instance.
  logic        we_prev    = 1'b0;
  logic [15:0] prev_addr  = '0;
  logic [7:0]  prev_wdata = '0;
  int          wcnt       = 0;

  always @(negedge clk) begin
    int          nw;
    logic        a;
    logic [23:0] e;
    if (!rst_n[sel]) begin
      we_prev <= 1'b0;
      ack_r   <= 1'b0;
    end else if (mon_we[sel]) begin
      if (!we_prev) begin
        nw = ack_mode ? int'($urandom_range(0, 3)) : 0;
      end else begin
        check("hold_addr", 32'(mon_addr[sel]), 32'(prev_addr));
        check("hold_data", 32'(mon_wdata[sel]), 32'(prev_wdata));
        nw = wcnt - 1;
      end
      a = (nw == 0);
      if (a) begin
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(mon_addr[sel]), 32'(e[23:8]));
          check("wr_data", 32'(mon_wdata[sel]), 32'(e[7:0]));
        end
        $display("[TB] inst%0d write addr=%04h data=%02h", sel, mon_addr[sel], mon_wdata[sel]);
      end
      wcnt       <= nw;
      ack_r      <= a;
      we_prev    <= 1'b1;
      prev_addr  <= mon_addr[sel];
      prev_wdata <= mon_wdata[sel];
    end else begin
      ack_r   <= 1'b0;
      we_prev <= 1'b0;
    end
  end

  task automatic load_expect(input int inst, output logic [7:0] csum);
    logic [7:0]  d;
    logic [15:0] ad;
    exp_q.delete();
    csum = '0;
    for (int i = 0; i < P_LEN[inst]; i++) begin
      d  = rom_byte(8'(i));
      ad = P_BASE[inst] + 16'(i);
      exp_q.push_back({ad, d});
      csum = csum + d;
    end
  endtask

  // Counts rising edges until done; p1/p2 select edges after which start is
  // pulsed for one cycle.
  task automatic wait_done(input int budget, input int p1, input int p2, output int edges);
    edges = 0;
    forever begin
      @(posedge clk);
      #1;
      edges++;
      start[sel] = (edges == p1) || (edges == p2);
      if (mon_done[sel]) break;
      if (edges >= budget) begin
        check("done_timeout", 32'(mon_done[sel]), 32'd1);
        break;
      end
    end
    start[sel] = 1'b0;
  endtask

  initial begin
    int         edges;
    logic [7:0] exp_csum;
    bit         found;

    for (int i = 0; i < N_INST; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
    end

    // 1: full 256-byte copy, no wait states
    sel = 0; ack_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("s1_rst_we",   32'(mon_we[0]),   32'd0);
    check("s1_rst_done", 32'(mon_done[0]), 32'd0);
    check("s1_rst_halt", 32'(mon_halt[0]), 32'd1);
    check("s1_rst_busy", 32'(mon_busy[0]), 32'd1);
    check("s1_rst_csum", 32'(mon_csum[0]), 32'd0);
    load_expect(0, exp_csum);
    rst_n[0] = 1'b1;
    wait_done(900, -1, -1, edges);
    check("s1_edges", 32'(edges), 32'd768);
    check("s1_halt",  32'(mon_halt[0]), 32'd0);
    check("s1_busy",  32'(mon_busy[0]), 32'd0);
    check("s1_csum",  32'(mon_csum[0]), 32'(exp_csum));
    check("s1_left",  32'(exp_q.size()), 32'd0);

    // 2: random wait states
    @(negedge clk); rst_n[0] = 1'b0;
    @(negedge clk);
    ack_mode = 1'b1;
    load_expect(0, exp_csum);
    rst_n[0] = 1'b1;
    wait_done(256 * 8 + 20, -1, -1, edges);
    check("s2_done",  32'(mon_done[0]), 32'd1);
    check("s2_range", 32'(edges >= 768 && edges <= 256 * 7), 32'd1);
    check("s2_csum",  32'(mon_csum[0]), 32'(exp_csum));
    check("s2_left",  32'(exp_q.size()), 32'd0);

    // 3: destination wraps past FFFF
    @(negedge clk); rst_n[0] = 1'b0;
    sel = 1; ack_mode = 1'b0;
    @(negedge clk);
    load_expect(1, exp_csum);
    rst_n[1] = 1'b1;
    wait_done(200, -1, -1, edges);
    check("s3_edges", 32'(edges), 32'd96);
    check("s3_csum",  32'(mon_csum[1]), 32'(exp_csum));
    check("s3_left",  32'(exp_q.size()), 32'd0);

    // 4: LEN = 1
    @(negedge clk); rst_n[1] = 1'b0;
    sel = 2;
    @(negedge clk);
    load_expect(2, exp_csum);
    rst_n[2] = 1'b1;
    wait_done(20, -1, -1, edges);
    check("s4_edges", 32'(edges), 32'd3);
    check("s4_csum",  32'(mon_csum[2]), 32'h5A);
    check("s4_left",  32'(exp_q.size()), 32'd0);

    // 5: reset during byte 100's WRITE
    @(negedge clk); rst_n[2] = 1'b0;
    sel = 0;
    @(negedge clk);
    load_expect(0, exp_csum);
    rst_n[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      found = mon_we[0] && (mon_addr[0] == 16'hFF64);
    end
    check("s5_reach_byte100", 32'(found), 32'd1);
    #2 rst_n[0] = 1'b0;
    #1;
    check("s5_rst_we",   32'(mon_we[0]),   32'd0);
    check("s5_rst_halt", 32'(mon_halt[0]), 32'd1);
    check("s5_rst_done", 32'(mon_done[0]), 32'd0);
    check("s5_rst_csum", 32'(mon_csum[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    load_expect(0, exp_csum);
    rst_n[0] = 1'b1;
    wait_done(900, -1, -1, edges);
    check("s5_edges", 32'(edges), 32'd768);
    check("s5_csum",  32'(mon_csum[0]), 32'(exp_csum));
    check("s5_left",  32'(exp_q.size()), 32'd0);

    // 6: AUTO_START = 0, start handling
    @(negedge clk); rst_n[0] = 1'b0;
    sel = 3;
    exp_q.delete();
    @(negedge clk);
    rst_n[3] = 1'b1;
    repeat (20) @(negedge clk);
    check("s6_idle_busy", 32'(mon_busy[3]), 32'd0);
    check("s6_idle_halt", 32'(mon_halt[3]), 32'd1);
    check("s6_idle_done", 32'(mon_done[3]), 32'd0);
    load_expect(3, exp_csum);
    start[3] = 1'b1;
    @(posedge clk); #1 start[3] = 1'b0;
    check("s6_start_busy", 32'(mon_busy[3]), 32'd1);
    // start pulses during copy, including on the final-ack edge, are ignored
    wait_done(100, 5, 3 * 16 - 1, edges);
    check("s6_edges", 32'(edges), 32'd48);
    check("s6_csum",  32'(mon_csum[3]), 32'(exp_csum));
    repeat (2) @(negedge clk);
    check("s6_done_hold", 32'(mon_done[3]), 32'd1);
    check("s6_busy_hold", 32'(mon_busy[3]), 32'd0);
    check("s6_left",      32'(exp_q.size()), 32'd0);
    // start in DONE re-runs the copy
    load_expect(3, exp_csum);
    start[3] = 1'b1;
    @(posedge clk); #1 start[3] = 1'b0;
    check("s6_rerun_done", 32'(mon_done[3]), 32'd0);
    check("s6_rerun_halt", 32'(mon_halt[3]), 32'd1);
    check("s6_rerun_csum", 32'(mon_csum[3]), 32'd0);
    wait_done(100, -1, -1, edges);
    check("s6_rerun_edges", 32'(edges), 32'd48);
    check("s6_rerun_csum2", 32'(mon_csum[3]), 32'(exp_csum));
    check("s6_rerun_left",  32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
